// File: rtl/complex_mul_issue_ctrl.sv
// Issue/return controller around a fixed-latency complex multiplier: tag pipe, response FIFO, credits.
// Optional statistics outputs are built when CMUL_ISSUE_STATS_EN is defined.
module complex_mul_issue_ctrl #(
  parameter int unsigned LATENCY   = 7,
  parameter int unsigned RSP_DEPTH = 8,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_a_real,
  input  logic [31:0]                req_a_imag,
  input  logic [31:0]                req_b_real,
  input  logic [31:0]                req_b_imag,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       mul_in_valid,
  output logic [31:0]                mul_a_real,
  output logic [31:0]                mul_a_imag,
  output logic [31:0]                mul_b_real,
  output logic [31:0]                mul_b_imag,
  input  logic                       mul_out_valid,
  input  logic [31:0]                mul_res_real,
  input  logic [31:0]                mul_res_imag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_real,
  output logic [31:0]                rsp_imag,
  output logic [TAG_W-1:0]           rsp_tag,
  input  logic                       flush,
  output logic                       busy,
  output logic                       err_latency
`ifdef CMUL_ISSUE_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall,
  output logic [$clog2(RSP_DEPTH):0] stat_max_occ
`endif
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned QW    = $clog2(LATENCY + 1);
  localparam int unsigned ENT_W = 64 + TAG_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   ready_d;
  logic                   busy_d;

  logic                   accept;
  logic                   head_v;
  logic [TAG_W-1:0]       head_tag;
  logic                   mul_ok;
  logic                   lat_err;
  logic                   push;
  logic                   pop;
  logic                   load;
  logic                   rsp_valid_d;

  logic [TAG_W-1:0]       mul_tag_q;
  logic [LATENCY-1:0]     pipe_v;
  logic [TAG_W-1:0]       pipe_tag [LATENCY];
  logic [QW-1:0]          quiet_q;

  logic [ENT_W-1:0]       mem [RSP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       mem_cnt_q;
  logic [CNT_W-1:0]       mem_cnt_d;
  logic [CNT_W-1:0]       in_flight_q;
  logic [CNT_W-1:0]       in_flight_d;
  logic [CNT_W-1:0]       occ_q;
  logic [CNT_W-1:0]       occ_d;

  // Flush wins over a same-cycle request.
  assign accept   = req_valid && req_ready && !flush;
  assign head_v   = pipe_v[LATENCY-1];
  assign head_tag = pipe_tag[LATENCY-1];
  // Stale multiplier results from before a reset are ignored until the pipe has emptied.
  assign mul_ok   = mul_out_valid && (quiet_q == '0);
  assign lat_err  = (quiet_q == '0) && (head_v != mul_out_valid);
  assign push     = head_v && mul_ok;
  assign pop      = rsp_valid && rsp_ready;
  assign load     = (mem_cnt_q != '0) && (!rsp_valid || pop);

  always_comb begin
    rsp_valid_d = rsp_valid;
    if (load) begin
      rsp_valid_d = 1'b1;
    end else if (pop) begin
      rsp_valid_d = 1'b0;
    end
    in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(head_v);
    mem_cnt_d   = mem_cnt_q + CNT_W'(push) - CNT_W'(load);
    occ_q       = in_flight_q + mem_cnt_q + CNT_W'(rsp_valid);
    occ_d       = in_flight_d + mem_cnt_d + CNT_W'(rsp_valid_d);
  end

  // FSM state register; ready/busy are registered from next-cycle values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= ready_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
        end else if ((occ_q == '0) && !accept) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!flush && (occ_q == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    ready_d = (state_d != DRAIN) && (occ_d < CNT_W'(RSP_DEPTH));
    busy_d  = (state_d != IDLE);
  end

  // Issue registers, expected-valid pipe, counters and response output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_in_valid <= 1'b0;
      mul_a_real   <= '0;
      mul_a_imag   <= '0;
      mul_b_real   <= '0;
      mul_b_imag   <= '0;
      mul_tag_q    <= '0;
      pipe_v       <= '0;
      quiet_q      <= QW'(LATENCY);
      in_flight_q  <= '0;
      mem_cnt_q    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rsp_valid    <= 1'b0;
      rsp_real     <= '0;
      rsp_imag     <= '0;
      rsp_tag      <= '0;
      err_latency  <= 1'b0;
    end else begin
      mul_in_valid <= accept;
      if (accept) begin
        mul_a_real <= req_a_real;
        mul_a_imag <= req_a_imag;
        mul_b_real <= req_b_real;
        mul_b_imag <= req_b_imag;
        mul_tag_q  <= req_tag;
      end
      pipe_v[0] <= mul_in_valid;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end
      if (quiet_q != '0) begin
        quiet_q <= quiet_q - QW'(1);
      end
      in_flight_q <= in_flight_d;
      mem_cnt_q   <= mem_cnt_d;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        {rsp_real, rsp_imag, rsp_tag} <= mem[rd_ptr];
      end
      rsp_valid   <= rsp_valid_d;
      err_latency <= err_latency | lat_err;
    end
  end

  // Payload storage needs no reset.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= mul_tag_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
    if (push) begin
      mem[wr_ptr] <= {mul_res_real, mul_res_imag, head_tag};
    end
  end

`ifdef CMUL_ISSUE_STATS_EN
  // Saturating activity counters and peak occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_stall   <= '0;
      stat_max_occ <= '0;
    end else begin
      if (accept && (stat_issued != '1)) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (req_valid && !req_ready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if (occ_d > stat_max_occ) begin
        stat_max_occ <= occ_d;
      end
    end
  end
`endif

endmodule
